// File: rtl/ttd_pkg.sv
// Shared types and default parameters for the time-to-digital conversion sequencer.
// Pure declarations; no latency or flow control of its own.
package ttd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISCHARGE,
        RAMP,
        ACCUM,
        OUT
    } ttd_state_e;

    localparam int TTD_WIDTH      = 11;
    localparam int TTD_RST_CYCLES = 16;
    localparam int TTD_AVG_LOG2   = 2;

endpackage

// File: rtl/ttd_cmp_sync.sv
// Comparator synchronizer: two flops then a rising-edge detect, rise is a one-cycle pulse.
// Latency two clk edges from a stable async_in rise to rise; no backpressure.
module ttd_cmp_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/ttd_seq.sv
// TDC conversion sequencer: discharge/ramp cycles timed against the comparator, averaged result.
// Result registered one cycle after the last ACCUM; held in OUT until data_ready.
module ttd_seq
    import ttd_pkg::*;
#(
    parameter int WIDTH      = TTD_WIDTH,
    parameter int RST_CYCLES = TTD_RST_CYCLES,
    parameter int AVG_LOG2   = TTD_AVG_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             cmp_in,
    output logic             rst_cap,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             err,
    output logic             data_valid,
    input  logic             data_ready
);

    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(RST_CYCLES - 1);

    ttd_state_e       state_q, state_d;
    logic [DC_W-1:0]  dcnt_q, dcnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             eflag_q, eflag_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             derr_q, derr_d;
    logic             dvld_q, dvld_d;
    logic [ACC_W-1:0] acc_new;
    logic             cmp_rise;

    ttd_cmp_sync u_cmp_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cmp_in),
        .rise     (cmp_rise)
    );

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        eflag_d  = eflag_q;
        acc_d    = acc_q;
        dout_d   = dout_q;
        derr_d   = derr_q;
        dvld_d   = dvld_q;
        acc_new  = acc_q + ACC_W'(sample_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DISCHARGE;
                    dcnt_d  = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    eflag_d = 1'b0;
                end
            end
            DISCHARGE: begin
                if (dcnt_q == DC_LAST) begin
                    state_d = RAMP;
                    cnt_d   = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            RAMP: begin
                // An edge landing on the all-ones count still counts as a real sample.
                if (cmp_rise) begin
                    sample_d = cnt_q;
                    state_d  = ACCUM;
                end else if (cnt_q == CNT_MAX) begin
                    sample_d = CNT_MAX;
                    eflag_d  = 1'b1;
                    state_d  = ACCUM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACCUM: begin
                acc_d = acc_new;
                if (idx_q == IDX_LAST) begin
                    dout_d  = acc_new[ACC_W-1:AVG_LOG2];
                    derr_d  = eflag_q;
                    dvld_d  = 1'b1;
                    state_d = OUT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    dcnt_d  = '0;
                    state_d = DISCHARGE;
                end
            end
            OUT: begin
                if (data_ready) begin
                    dvld_d = 1'b0;
                    if (continuous) begin
                        state_d = DISCHARGE;
                        dcnt_d  = '0;
                        acc_d   = '0;
                        idx_d   = '0;
                        eflag_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dcnt_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            sample_q <= '0;
            eflag_q  <= 1'b0;
            acc_q    <= '0;
            dout_q   <= '0;
            derr_q   <= 1'b0;
            dvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            eflag_q  <= eflag_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
            derr_q   <= derr_d;
            dvld_q   <= dvld_d;
        end
    end

    assign rst_cap    = (state_q != RAMP);
    assign busy       = (state_q != IDLE);
    assign data_out   = dout_q;
    assign err        = derr_q;
    assign data_valid = dvld_q;

endmodule

// File: tb/tb_ttd_seq.sv
// Directed bench for ttd_seq: comparator edges placed at known ramp counts, hand-computed results.
module tb_ttd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic        cmp_in;
    logic        rst_cap;
    logic        busy;
    logic [10:0] data_out;
    logic        err;
    logic        data_valid;
    logic        data_ready;

    int checks = 0;
    int errors = 0;
    bit poke_start = 1'b0;

    ttd_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .cmp_in     (cmp_in),
        .rst_cap    (rst_cap),
        .busy       (busy),
        .data_out   (data_out),
        .err        (err),
        .data_valid (data_valid),
        .data_ready (data_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // k >= 0: comparator rises during the cycle the ramp counter equals k.
    // k == -1: comparator stays low (timeout). k == -2: comparator already high at ramp entry.
    task automatic do_ramp(input int k, output int hi, output int rl);
        hi = 0;
        rl = 0;
        cmp_in = (k == -2);
        while (rst_cap !== 1'b0 && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        if (hi >= 200) begin
            chk("ramp_entry_bound", 0, 1);
            return;
        end
        rl = 1;
        if (poke_start) start = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            start = 1'b0;
            rl++;
        end
        if (k >= 0) cmp_in = 1'b1;
        while (rst_cap === 1'b0 && rl < 2200) begin
            @(negedge clk);
            start = 1'b0;
            if (rst_cap === 1'b0) rl++;
        end
        if (rl >= 2200) chk("ramp_exit_bound", 0, 1);
        cmp_in = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int k0, input int k1, input int k2, input int k3,
                           input int exp_d, input logic exp_e, input int first_hi,
                           input string tag);
        int ks[4];
        int hi;
        int rl;
        ks[0] = k0; ks[1] = k1; ks[2] = k2; ks[3] = k3;
        for (int i = 0; i < 4; i++) begin
            do_ramp(ks[i], hi, rl);
            chk($sformatf("%s_dis%0d", tag, i), hi, (i == 0) ? first_hi : 17);
            chk($sformatf("%s_ramp%0d", tag, i), rl, (ks[i] >= 0) ? ks[i] + 3 : 2048);
        end
        @(negedge clk);
        chk({tag, "_vld"}, data_valid, 1);
        chk({tag, "_data"}, data_out, exp_d);
        chk({tag, "_err"}, err, exp_e);
    endtask

    task automatic accept();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin
        int hi;
        int rl;
        int bad;
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        cmp_in = 1'b0;
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rst_cap", rst_cap, 1);
        chk("rst_busy", busy, 0);
        chk("rst_vld", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Asynchronous reset in the middle of a ramp.
        pulse_start();
        hi = 0;
        while (rst_cap !== 1'b0 && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        chk("mid_ramp_reached", rst_cap, 0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rst_cap", rst_cap, 1);
        chk("arst_busy", busy, 0);
        chk("arst_vld", data_valid, 0);
        chk("arst_data", data_out, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Nominal: edges at counter 100 -> sample 102.
        pulse_start();
        collect(100, 100, 100, 100, 102, 1'b0, 16, "nom");
        accept();
        chk("nom_idle_busy", busy, 0);

        // Truncating average, with start poked during every ramp.
        poke_start = 1'b1;
        pulse_start();
        collect(98, 99, 99, 99, 100, 1'b0, 16, "trunc");
        poke_start = 1'b0;
        accept();
        chk("trunc_idle_busy", busy, 0);
        repeat (40) @(negedge clk);
        chk("trunc_single_busy", busy, 0);
        chk("trunc_single_vld", data_valid, 0);

        // Full timeouts.
        pulse_start();
        collect(-1, -1, -1, -1, 2047, 1'b1, 16, "tout");
        accept();

        // One timeout among three edges at counter 10.
        pulse_start();
        collect(-1, 10, 10, 10, 520, 1'b1, 16, "mix");
        accept();

        // Comparator already high on ramp entry times out.
        pulse_start();
        collect(-2, 10, 10, 10, 520, 1'b1, 16, "prehigh");
        accept();

        // Edge and all-ones count coincide: edge wins, no error.
        pulse_start();
        collect(2045, 2045, 2045, 2045, 2047, 1'b0, 16, "edge_max");
        accept();

        // Handshake hold, start pokes during OUT, continuous restart.
        pulse_start();
        collect(50, 50, 50, 50, 52, 1'b0, 16, "hold");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            start = (i % 7 == 3);
            @(negedge clk);
            if (data_valid !== 1'b1 || data_out !== 11'd52 || err !== 1'b0) bad++;
        end
        start = 1'b0;
        chk("hold_stable", bad, 0);
        continuous = 1'b1;
        accept();
        chk("cont_busy", busy, 1);
        chk("cont_vld", data_valid, 0);
        chk("cont_rst_cap", rst_cap, 1);
        continuous = 1'b0;
        collect(20, 20, 20, 20, 22, 1'b0, 16, "cont");
        accept();
        chk("cont_end_busy", busy, 0);
        chk("cont_end_vld", data_valid, 0);
        repeat (40) @(negedge clk);
        chk("cont_end_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
